// File: rtl/sarlock_key_loader_pkg.sv
// Shared types and constants for the SARLock key loader: FSM state encoding,
// default key width, fail-counter width and the running-parity helper.
package sarlock_pkg;

  localparam int KEY_W_DEF  = 8;
  localparam int FAIL_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4,
    ST_FAULT = 3'd5
  } loader_state_t;

  // Fold one more received bit into an even-parity accumulator.
  function automatic logic parity_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/sarlock_key_loader_if.sv
// Key-provisioning bus: serial bit input side plus the parallel key/status side.
// The loader uses the slave modport; the key source/consumer uses master.
interface sarlock_key_loader_if
  import sarlock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) ();
  logic                  start_i;
  logic                  bit_valid_i;
  logic                  bit_i;
  logic                  bit_ready_o;
  logic [KEY_W-1:0]      key_o;
  logic                  key_valid_o;
  logic                  busy_o;
  logic                  err_o;
  logic                  fault_o;
  logic [FAIL_CNT_W-1:0] fail_cnt_o;

  modport master (
    output start_i, bit_valid_i, bit_i,
    input  bit_ready_o, key_o, key_valid_o, busy_o, err_o, fault_o, fail_cnt_o
  );

  modport slave (
    input  start_i, bit_valid_i, bit_i,
    output bit_ready_o, key_o, key_valid_o, busy_o, err_o, fault_o, fail_cnt_o
  );
endinterface

// File: rtl/sarlock_key_shreg.sv
// Serial key capture: shift register for the KEY_W key bits, accepted-bit counter
// and running even parity over key bits plus the trailing parity bit.
module sarlock_key_shreg
  import sarlock_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic             frame_done_o,
  output logic             parity_ok_o,
  output logic [KEY_W-1:0] key_bits_o
);
  localparam int              CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W);

  logic [KEY_W-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else if (clr_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else if (shift_i) begin
      par_q <= parity_step(par_q, bit_i);
      // The parity bit only feeds the accumulator, so the key stays intact.
      if (cnt_q != LAST) begin
        shreg_q <= {shreg_q[KEY_W-2:0], bit_i};
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_done_o = shift_i && (cnt_q == LAST);
  assign parity_ok_o  = ~par_q;
  assign key_bits_o   = shreg_q;

endmodule

// File: rtl/sarlock_key_loader.sv
// SARLock key loader: serial key intake, parity check, fail counting and sticky
// lockout. Define SARLOCK_KEY_MASK_EN to descramble the key with MASK on release.
module sarlock_key_loader
  import sarlock_pkg::*;
#(
  parameter int               KEY_W    = KEY_W_DEF,
  parameter int               MAX_FAIL = 3,
  parameter logic [KEY_W-1:0] MASK     = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sarlock_key_loader_if.slave  key_bus
);
`ifdef SARLOCK_KEY_MASK_EN
  localparam logic [KEY_W-1:0] KEY_MASK = MASK;
`else
  // Feature off: mask folds to zero so the received key passes straight through.
  localparam logic [KEY_W-1:0] KEY_MASK = MASK & {KEY_W{1'b0}};
`endif
  localparam logic [FAIL_CNT_W-1:0] MAX_FAIL_C = FAIL_CNT_W'(MAX_FAIL);

  loader_state_t         state_q;
  logic [KEY_W-1:0]      key_q;
  logic                  key_valid_q;
  logic                  bit_ready_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  fault_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_d;

  logic             restart;
  logic             shift_en;
  logic             frame_done;
  logic             parity_ok;
  logic [KEY_W-1:0] key_bits;

  assign restart  = key_bus.start_i && (state_q == ST_IDLE || state_q == ST_SHIFT ||
                                        state_q == ST_DONE || state_q == ST_ERROR);
  assign shift_en = (state_q == ST_SHIFT) && key_bus.bit_valid_i && !key_bus.start_i;

  assign fail_cnt_d = (fail_cnt_q == MAX_FAIL_C) ? fail_cnt_q : fail_cnt_q + FAIL_CNT_W'(1);

  sarlock_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (restart),
    .shift_i      (shift_en),
    .bit_i        (key_bus.bit_i),
    .frame_done_o (frame_done),
    .parity_ok_o  (parity_ok),
    .key_bits_o   (key_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      fault_q     <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR, ST_SHIFT: begin
          if (key_bus.start_i) begin
            state_q     <= ST_SHIFT;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            bit_ready_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (state_q == ST_SHIFT && frame_done) begin
            state_q     <= ST_CHECK;
            bit_ready_q <= 1'b0;
          end
        end
        ST_CHECK: begin
          busy_q <= 1'b0;
          if (parity_ok) begin
            state_q     <= ST_DONE;
            key_q       <= key_bits ^ KEY_MASK;
            key_valid_q <= 1'b1;
            fail_cnt_q  <= '0;
          end else begin
            err_q      <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == MAX_FAIL_C) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
            end
          end
        end
        ST_FAULT: state_q <= ST_FAULT;
        default:  state_q <= ST_FAULT;
      endcase
    end
  end

  assign key_bus.key_o       = key_q;
  assign key_bus.key_valid_o = key_valid_q;
  assign key_bus.bit_ready_o = bit_ready_q;
  assign key_bus.busy_o      = busy_q;
  assign key_bus.err_o       = err_q;
  assign key_bus.fault_o     = fault_q;
  assign key_bus.fail_cnt_o  = fail_cnt_q;

endmodule

// File: tb/tb_sarlock_key_loader.sv
// Directed bench for sarlock_key_loader: clean load, parity error, restart,
// stall, start collisions, lockout and async reset. Honours SARLOCK_KEY_MASK_EN.
module tb_sarlock_key_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef SARLOCK_KEY_MASK_EN
  localparam logic [7:0] EXP_6D = 8'hC8;
  localparam logic [7:0] EXP_3C = 8'h99;
`else
  localparam logic [7:0] EXP_6D = 8'h6D;
  localparam logic [7:0] EXP_3C = 8'h3C;
`endif

  always #5 clk = ~clk;

  sarlock_key_loader_if #(.KEY_W(8)) bus_if ();

  sarlock_key_loader #(.KEY_W(8), .MAX_FAIL(3), .MASK(8'hA5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_bus (bus_if)
  );

  task automatic pulse_start();
    @(negedge clk);
    bus_if.start_i = 1'b1;
    @(negedge clk);
    bus_if.start_i = 1'b0;
  endtask

  // Drives nbits key bits (MSB first) then optionally the parity bit; returns at the
  // negedge after the last accepted bit. ready_ok reports bit_ready_o seen high throughout.
  task automatic send_bits(input logic [7:0] k, input int nbits, input bit with_par,
                           input logic par, input int max_gap, output bit ready_ok);
    ready_ok = 1'b1;
    for (int i = 0; i < nbits + (with_par ? 1 : 0); i++) begin
      bus_if.bit_valid_i = 1'b1;
      bus_if.bit_i       = (i < nbits) ? k[7-i] : par;
      if (bus_if.bit_ready_o !== 1'b1) ready_ok = 1'b0;
      @(negedge clk);
      bus_if.bit_valid_i = 1'b0;
      if (max_gap > 0 && i < nbits + (with_par ? 1 : 0) - 1) begin
        int gap;
        gap = $urandom_range(1, max_gap);
        for (int g = 0; g < gap; g++) begin
          if (bus_if.bit_ready_o !== 1'b1) ready_ok = 1'b0;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus_if.key_o !== 8'h00) begin errors++; $display("FAIL reset_key got %h exp 00", bus_if.key_o); end
    checks++; if (bus_if.key_valid_o !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b exp 0", bus_if.key_valid_o); end
    checks++; if (bus_if.bit_ready_o !== 1'b0) begin errors++; $display("FAIL reset_bit_ready got %b exp 0", bus_if.bit_ready_o); end
    checks++; if (bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_if.busy_o); end
    checks++; if (bus_if.err_o !== 1'b0 || bus_if.fault_o !== 1'b0) begin errors++; $display("FAIL reset_err_fault got %b%b exp 00", bus_if.err_o, bus_if.fault_o); end
    checks++; if (bus_if.fail_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_fail_cnt got %0d exp 0", bus_if.fail_cnt_o); end
    $display("reset: key=%h valid=%b cnt=%0d", bus_if.key_o, bus_if.key_valid_o, bus_if.fail_cnt_o);
  endtask

  task automatic test_clean_load();
    bit rdy;
    pulse_start();
    checks++; if (bus_if.bit_ready_o !== 1'b1 || bus_if.busy_o !== 1'b1) begin errors++; $display("FAIL clean_shift_flags got rdy=%b busy=%b exp 1 1", bus_if.bit_ready_o, bus_if.busy_o); end
    send_bits(8'h6D, 8, 1'b1, 1'b1, 0, rdy);
    // CHECK cycle: verdict not out yet.
    checks++; if (bus_if.key_valid_o !== 1'b0 || bus_if.busy_o !== 1'b1 || bus_if.bit_ready_o !== 1'b0) begin errors++; $display("FAIL clean_check_cycle got valid=%b busy=%b rdy=%b exp 0 1 0", bus_if.key_valid_o, bus_if.busy_o, bus_if.bit_ready_o); end
    @(negedge clk);
    checks++; if (bus_if.key_valid_o !== 1'b1 || bus_if.key_o !== EXP_6D) begin errors++; $display("FAIL clean_key got %h/%b exp %h/1", bus_if.key_o, bus_if.key_valid_o, EXP_6D); end
    checks++; if (bus_if.fail_cnt_o !== 4'd0 || bus_if.busy_o !== 1'b0 || bus_if.err_o !== 1'b0) begin errors++; $display("FAIL clean_status got cnt=%0d busy=%b err=%b exp 0 0 0", bus_if.fail_cnt_o, bus_if.busy_o, bus_if.err_o); end
    $display("clean load: key=%h valid=%b", bus_if.key_o, bus_if.key_valid_o);
  endtask

  task automatic test_bad_parity();
    bit rdy;
    pulse_start();
    checks++; if (bus_if.key_valid_o !== 1'b0 || bus_if.key_o !== 8'h00) begin errors++; $display("FAIL bad_start_clears got %h/%b exp 00/0", bus_if.key_o, bus_if.key_valid_o); end
    send_bits(8'h6D, 8, 1'b1, 1'b0, 0, rdy);
    @(negedge clk);
    checks++; if (bus_if.err_o !== 1'b1 || bus_if.fail_cnt_o !== 4'd1) begin errors++; $display("FAIL bad_err got err=%b cnt=%0d exp 1 1", bus_if.err_o, bus_if.fail_cnt_o); end
    checks++; if (bus_if.key_o !== 8'h00 || bus_if.key_valid_o !== 1'b0 || bus_if.fault_o !== 1'b0) begin errors++; $display("FAIL bad_key got %h/%b fault=%b exp 00/0 0", bus_if.key_o, bus_if.key_valid_o, bus_if.fault_o); end
    $display("bad parity: err=%b cnt=%0d", bus_if.err_o, bus_if.fail_cnt_o);
  endtask

  task automatic test_restart();
    bit rdy;
    pulse_start();
    checks++; if (bus_if.err_o !== 1'b0) begin errors++; $display("FAIL restart_err_clear got %b exp 0", bus_if.err_o); end
    send_bits(8'hF0, 4, 1'b0, 1'b0, 0, rdy);
    pulse_start();
    checks++; if (bus_if.fail_cnt_o !== 4'd1 || bus_if.busy_o !== 1'b1) begin errors++; $display("FAIL restart_cnt_kept got cnt=%0d busy=%b exp 1 1", bus_if.fail_cnt_o, bus_if.busy_o); end
    send_bits(8'h3C, 8, 1'b1, 1'b0, 0, rdy);
    @(negedge clk);
    checks++; if (bus_if.key_o !== EXP_3C || bus_if.key_valid_o !== 1'b1 || bus_if.fail_cnt_o !== 4'd0) begin errors++; $display("FAIL restart_key got %h/%b cnt=%0d exp %h/1 0", bus_if.key_o, bus_if.key_valid_o, bus_if.fail_cnt_o, EXP_3C); end
    $display("restart: key=%h valid=%b", bus_if.key_o, bus_if.key_valid_o);
  endtask

  task automatic test_stall();
    bit rdy;
    pulse_start();
    send_bits(8'h6D, 8, 1'b1, 1'b1, 5, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL stall_ready got %b exp 1", rdy); end
    @(negedge clk);
    checks++; if (bus_if.key_o !== EXP_6D || bus_if.key_valid_o !== 1'b1) begin errors++; $display("FAIL stall_key got %h/%b exp %h/1", bus_if.key_o, bus_if.key_valid_o, EXP_6D); end
    $display("stall: key=%h valid=%b", bus_if.key_o, bus_if.key_valid_o);
  endtask

  task automatic test_start_collisions();
    bit rdy;
    // start with a strobed bit: the bit must not be taken as key bit 0.
    @(negedge clk);
    bus_if.start_i = 1'b1; bus_if.bit_valid_i = 1'b1; bus_if.bit_i = 1'b1;
    @(negedge clk);
    bus_if.start_i = 1'b0; bus_if.bit_valid_i = 1'b0;
    send_bits(8'h3C, 8, 1'b1, 1'b0, 0, rdy);
    // start during CHECK is ignored.
    bus_if.start_i = 1'b1;
    @(negedge clk);
    bus_if.start_i = 1'b0;
    checks++; if (bus_if.key_o !== EXP_3C || bus_if.key_valid_o !== 1'b1 || bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL collide_key got %h/%b busy=%b exp %h/1 0", bus_if.key_o, bus_if.key_valid_o, bus_if.busy_o, EXP_3C); end
    $display("start collisions: key=%h valid=%b", bus_if.key_o, bus_if.key_valid_o);
  endtask

  task automatic test_lockout();
    bit rdy;
    for (int n = 1; n <= 3; n++) begin
      pulse_start();
      send_bits(8'h6D, 8, 1'b1, 1'b0, 0, rdy);
      @(negedge clk);
      $display("lockout load %0d: cnt=%0d fault=%b", n, bus_if.fail_cnt_o, bus_if.fault_o);
    end
    checks++; if (bus_if.fault_o !== 1'b1 || bus_if.fail_cnt_o !== 4'd3) begin errors++; $display("FAIL lockout_fault got fault=%b cnt=%0d exp 1 3", bus_if.fault_o, bus_if.fail_cnt_o); end
    pulse_start();
    send_bits(8'h6D, 8, 1'b1, 1'b1, 0, rdy);
    @(negedge clk);
    checks++; if (bus_if.key_valid_o !== 1'b0 || bus_if.key_o !== 8'h00 || bus_if.bit_ready_o !== 1'b0 || bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL lockout_ignore got %h/%b rdy=%b busy=%b exp 00/0 0 0", bus_if.key_o, bus_if.key_valid_o, bus_if.bit_ready_o, bus_if.busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.fault_o !== 1'b0 || bus_if.fail_cnt_o !== 4'd0 || bus_if.err_o !== 1'b0) begin errors++; $display("FAIL lockout_reset got fault=%b cnt=%0d err=%b exp 0 0 0", bus_if.fault_o, bus_if.fail_cnt_o, bus_if.err_o); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("lockout cleared: fault=%b", bus_if.fault_o);
  endtask

  task automatic test_reset_midload();
    bit rdy;
    pulse_start();
    send_bits(8'hA0, 3, 1'b0, 1'b0, 0, rdy);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.busy_o !== 1'b0 || bus_if.bit_ready_o !== 1'b0) begin errors++; $display("FAIL midload_reset got busy=%b rdy=%b exp 0 0", bus_if.busy_o, bus_if.bit_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    // A full frame afterwards must load cleanly from a fresh counter.
    pulse_start();
    send_bits(8'h6D, 8, 1'b1, 1'b1, 0, rdy);
    @(negedge clk);
    checks++; if (bus_if.key_o !== EXP_6D || bus_if.key_valid_o !== 1'b1) begin errors++; $display("FAIL midload_reload got %h/%b exp %h/1", bus_if.key_o, bus_if.key_valid_o, EXP_6D); end
    $display("reset mid-load: key=%h valid=%b", bus_if.key_o, bus_if.key_valid_o);
  endtask

  initial begin
    bus_if.start_i     = 1'b0;
    bus_if.bit_valid_i = 1'b0;
    bus_if.bit_i       = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_clean_load();
    test_bad_parity();
    test_restart();
    test_stall();
    test_start_collisions();
    test_lockout();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running exp finished");
    $fatal(1, "watchdog");
  end
endmodule
